// File: rtl/mem_if_pkg.sv
// Shared definitions for the weight transfer sequencer: FSM state encoding,
// ctrl_pe field layout helpers and the weight namespace value.
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } xfer_state_e;

    // Namespace driven on ctrl_pe while weights move in either direction
    localparam logic [1:0] NAMESPACE_WEIGHT = 2'd1;

    // Index width that never collapses to zero bits
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One lane field is {pe_id, valid}
    function automatic int lane_field_width(input int pe_id_w);
        return pe_id_w + 1;
    endfunction

    // Lane fields sit above the namespace field, lane 0 lowest
    function automatic int lane_field_lsb(input int lane, input int pe_id_w, input int ns_w);
        return ns_w + lane * lane_field_width(pe_id_w);
    endfunction

    function automatic int ctrl_pe_width(input int lanes, input int pe_id_w, input int ns_w);
        return ns_w + lanes * lane_field_width(pe_id_w);
    endfunction

endpackage

// File: rtl/lane_pe_counter.sv
// Per-lane working counters for the weight transfer sequencer.
// Holds the remaining word count of each PE in the lane and reports the
// lowest-numbered PE that still has words outstanding.
module lane_pe_counter #(
    parameter int PES_PER_LANE = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int PE_ID_W      = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_load,
    input  logic [PES_PER_LANE*COUNT_WIDTH-1:0]   i_load_vec,
    input  logic                                  i_dec,
    output logic [PE_ID_W-1:0]                    o_pe_id,
    output logic                                  o_valid
);

    logic [COUNT_WIDTH-1:0] r_rem [PES_PER_LANE];

    // Priority-select the lowest PE with words left; pe_id is 0 when idle
    always_comb begin
        o_valid = 1'b0;
        o_pe_id = '0;
        for (int p = PES_PER_LANE - 1; p >= 0; p--) begin
            if (r_rem[p] != '0) begin
                o_valid = 1'b1;
                o_pe_id = PE_ID_W'(p);
            end
        end
    end

    // Load takes precedence so a clear (load of zeros) always wins over a beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < PES_PER_LANE; p++) begin
                r_rem[p] <= '0;
            end
        end else if (i_load) begin
            for (int p = 0; p < PES_PER_LANE; p++) begin
                r_rem[p] <= i_load_vec[p*COUNT_WIDTH +: COUNT_WIDTH];
            end
        end else if (i_dec && o_valid) begin
            for (int p = 0; p < PES_PER_LANE; p++) begin
                if (PE_ID_W'(p) == o_pe_id) begin
                    r_rem[p] <= r_rem[p] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/weight_xfer_sequencer.sv
// Weight transfer sequencer: moves per-PE weight words from the read buffer
// into the PEs (RD phase) or from the PEs into the write buffer (WR phase).
// Per-PE word counts are programmed at runtime while idle.
// Optional stall statistics are built when WEIGHT_XFER_STATS_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | accepting cfg writes, waiting for start_rd / start_wr
// RD      | read-in: pop read buffer, steer words to lane PEs
// WR      | write-back: push write buffer from lane PEs
// DONE    | one cycle, pulse rd_done or wr_done, then back to IDLE
module weight_xfer_sequencer
    import mem_if_pkg::*;
#(
    parameter int NUM_LANES       = 16,
    parameter int PES_PER_LANE    = 4,
    parameter int COUNT_WIDTH     = 16,
    parameter int NAMESPACE_WIDTH = 2,
    parameter logic [NAMESPACE_WIDTH-1:0] NAMESPACE_WEIGHT =
        NAMESPACE_WIDTH'(mem_if_pkg::NAMESPACE_WEIGHT),
    localparam int PE_ID_W   = id_width(PES_PER_LANE),
    localparam int LANE_W    = id_width(NUM_LANES),
    localparam int CTRL_PE_W = ctrl_pe_width(NUM_LANES, PE_ID_W, NAMESPACE_WIDTH)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cfg_we,
    input  logic [LANE_W-1:0]      cfg_lane,
    input  logic [PE_ID_W-1:0]     cfg_pe,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic                   start_rd,
    input  logic                   start_wr,
    input  logic                   abort,
    input  logic                   rd_buf_empty,
    output logic                   rd_buf_pop,
    input  logic                   wr_buf_full,
    output logic                   wr_buf_push,
    output logic [CTRL_PE_W-1:0]   ctrl_pe,
    output logic                   busy,
    output logic                   rd_done,
    output logic                   wr_done,
    output logic [31:0]            rd_stall_cycles,
    output logic [31:0]            wr_stall_cycles
);

    xfer_state_e r_state;
    logic        r_rd_done;
    logic        r_wr_done;

    logic [COUNT_WIDTH-1:0] r_cfg [NUM_LANES][PES_PER_LANE];

    logic [PES_PER_LANE*COUNT_WIDTH-1:0] w_load_vec [NUM_LANES];
    logic [PE_ID_W-1:0]                  w_pe_id    [NUM_LANES];
    logic [NUM_LANES-1:0]                w_lane_valid;

    logic w_in_rd;
    logic w_in_wr;
    logic w_in_phase;
    logic w_any_valid;
    logic w_accept;
    logic w_abort;
    logic w_load;
    logic w_beat_rd;
    logic w_beat_wr;
    logic w_dec;

    assign w_in_rd     = (r_state == ST_RD);
    assign w_in_wr     = (r_state == ST_WR);
    assign w_in_phase  = w_in_rd || w_in_wr;
    assign w_any_valid = |w_lane_valid;
    assign w_accept    = (r_state == ST_IDLE) && (start_rd || start_wr);
    assign w_abort     = w_in_phase && abort;
    // An abort reloads the lane counters with zeros, which clears them
    assign w_load      = w_accept || w_abort;
    assign w_beat_rd   = w_in_rd && !abort && w_any_valid && !rd_buf_empty;
    assign w_beat_wr   = w_in_wr && !abort && w_any_valid && !wr_buf_full;
    assign w_dec       = w_beat_rd || w_beat_wr;

    assign rd_buf_pop  = w_beat_rd;
    assign wr_buf_push = w_beat_wr;
    assign busy        = (r_state != ST_IDLE);
    assign rd_done     = r_rd_done;
    assign wr_done     = r_wr_done;

    // Per-PE count storage, writable only while idle; stray indices are dropped
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int g = 0; g < NUM_LANES; g++) begin
                for (int p = 0; p < PES_PER_LANE; p++) begin
                    r_cfg[g][p] <= '0;
                end
            end
        end else if ((r_state == ST_IDLE) && cfg_we) begin
            for (int g = 0; g < NUM_LANES; g++) begin
                for (int p = 0; p < PES_PER_LANE; p++) begin
                    if ((cfg_lane == LANE_W'(g)) && (cfg_pe == PE_ID_W'(p))) begin
                        r_cfg[g][p] <= cfg_count;
                    end
                end
            end
        end
    end

    // Phase sequencing; done pulses are registered on entry to DONE
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= ST_IDLE;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_rd) begin
                        r_state <= ST_RD;
                    end else if (start_wr) begin
                        r_state <= ST_WR;
                    end
                end
                ST_RD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (!w_any_valid) begin
                        r_state   <= ST_DONE;
                        r_rd_done <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (!w_any_valid) begin
                        r_state   <= ST_DONE;
                        r_wr_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        for (genvar p = 0; p < PES_PER_LANE; p++) begin : g_pe
            assign w_load_vec[g][p*COUNT_WIDTH +: COUNT_WIDTH] = w_abort ? '0 : r_cfg[g][p];
        end

        lane_pe_counter #(
            .PES_PER_LANE (PES_PER_LANE),
            .COUNT_WIDTH  (COUNT_WIDTH),
            .PE_ID_W      (PE_ID_W)
        ) u_lane_cnt (
            .i_clk      (ACLK),
            .i_rst_n    (ARESETN),
            .i_load     (w_load),
            .i_load_vec (w_load_vec[g]),
            .i_dec      (w_dec),
            .o_pe_id    (w_pe_id[g]),
            .o_valid    (w_lane_valid[g])
        );

        assign ctrl_pe[lane_field_lsb(g, PE_ID_W, NAMESPACE_WIDTH) +: lane_field_width(PE_ID_W)] =
            w_in_phase ? {w_pe_id[g], w_lane_valid[g]} : '0;
    end

    assign ctrl_pe[NAMESPACE_WIDTH-1:0] = w_in_phase ? NAMESPACE_WEIGHT : '0;

`ifdef WEIGHT_XFER_STATS_EN
    logic [31:0] r_rd_stall;
    logic [31:0] r_wr_stall;

    // Saturating stall counters, restarted whenever a new phase is accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rd_stall <= '0;
            r_wr_stall <= '0;
        end else if (w_accept) begin
            r_rd_stall <= '0;
            r_wr_stall <= '0;
        end else begin
            if (w_in_rd && w_any_valid && rd_buf_empty && (r_rd_stall != '1)) begin
                r_rd_stall <= r_rd_stall + 32'd1;
            end
            if (w_in_wr && w_any_valid && wr_buf_full && (r_wr_stall != '1)) begin
                r_wr_stall <= r_wr_stall + 32'd1;
            end
        end
    end

    assign rd_stall_cycles = r_rd_stall;
    assign wr_stall_cycles = r_wr_stall;
`else
    assign rd_stall_cycles = 32'd0;
    assign wr_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_weight_xfer_sequencer.sv
// Testbench for weight_xfer_sequencer with 2 lanes of 3 PEs.
// The reference model expands each lane's counts into the ordered list of
// PE ids it must emit and walks that list one word per beat.
module tb_weight_xfer_sequencer;

    localparam int NL  = 2;
    localparam int PPL = 3;
    localparam int CW  = 8;
    localparam int PW  = 2;
    localparam int LW  = 1;
    localparam int CTW = NL * (PW + 1) + 2;

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic           cfg_we = 1'b0;
    logic [LW-1:0]  cfg_lane = '0;
    logic [PW-1:0]  cfg_pe = '0;
    logic [CW-1:0]  cfg_count = '0;
    logic           start_rd = 1'b0;
    logic           start_wr = 1'b0;
    logic           abort = 1'b0;
    logic           rd_buf_empty = 1'b0;
    logic           rd_buf_pop;
    logic           wr_buf_full = 1'b0;
    logic           wr_buf_push;
    logic [CTW-1:0] ctrl_pe;
    logic           busy;
    logic           rd_done;
    logic           wr_done;
    logic [31:0]    rd_stall_cycles;
    logic [31:0]    wr_stall_cycles;

    weight_xfer_sequencer #(
        .NUM_LANES       (NL),
        .PES_PER_LANE    (PPL),
        .COUNT_WIDTH     (CW),
        .NAMESPACE_WIDTH (2)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .cfg_we          (cfg_we),
        .cfg_lane        (cfg_lane),
        .cfg_pe          (cfg_pe),
        .cfg_count       (cfg_count),
        .start_rd        (start_rd),
        .start_wr        (start_wr),
        .abort           (abort),
        .rd_buf_empty    (rd_buf_empty),
        .rd_buf_pop      (rd_buf_pop),
        .wr_buf_full     (wr_buf_full),
        .wr_buf_push     (wr_buf_push),
        .ctrl_pe         (ctrl_pe),
        .busy            (busy),
        .rd_done         (rd_done),
        .wr_done         (wr_done),
        .rd_stall_cycles (rd_stall_cycles),
        .wr_stall_cycles (wr_stall_cycles)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_bad = 0;

    // model: phase 0 idle, 1 read-in, 2 write-back, 3 done
    int      m_phase;
    bit      m_done_rd;
    int      m_cfg [NL][PPL];
    int      m_seq [NL][$];
    int      m_idx [NL];
    longint  m_rd_stall;
    longint  m_wr_stall;

    // samples taken in the last step
    logic           o_pop, o_push, o_rd_done, o_wr_done;
    logic [CTW-1:0] o_ctrl;
    logic [CTW-1:0] q_beat_ctrl [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_done_rd = 1'b0;
        m_rd_stall = 0;
        m_wr_stall = 0;
        for (int g = 0; g < NL; g++) begin
            m_seq[g].delete();
            m_idx[g] = 0;
            for (int p = 0; p < PPL; p++) m_cfg[g][p] = 0;
        end
    endtask

    function automatic bit lane_valid(input int g);
        return ((m_phase == 1) || (m_phase == 2)) && (m_idx[g] < m_seq[g].size());
    endfunction

    function automatic int lane_pe(input int g);
        return lane_valid(g) ? m_seq[g][m_idx[g]] : 0;
    endfunction

    function automatic logic [CTW-1:0] exp_ctrl();
        logic [CTW-1:0] v;
        logic [PW-1:0]  pe;
        v = '0;
        if ((m_phase == 1) || (m_phase == 2)) begin
            v[1:0] = 2'd1;
            for (int g = 0; g < NL; g++) begin
                pe = PW'(lane_pe(g));
                v[2 + g*3 +: 3] = {pe, lane_valid(g)};
            end
        end
        return v;
    endfunction

    task automatic model_update(input bit any, input bit beat);
        if (!ARESETN) begin
            model_reset();
            return;
        end
        if ((m_phase == 1) && any && rd_buf_empty && (m_rd_stall < 64'hFFFF_FFFF)) m_rd_stall++;
        if ((m_phase == 2) && any && wr_buf_full && (m_wr_stall < 64'hFFFF_FFFF)) m_wr_stall++;
        case (m_phase)
            0: begin
                if (start_rd || start_wr) begin
                    for (int g = 0; g < NL; g++) begin
                        m_seq[g].delete();
                        m_idx[g] = 0;
                        for (int p = 0; p < PPL; p++)
                            for (int k = 0; k < m_cfg[g][p]; k++) m_seq[g].push_back(p);
                    end
                    m_rd_stall = 0;
                    m_wr_stall = 0;
                    m_phase = start_rd ? 1 : 2;
                end
                if (cfg_we && (int'(cfg_pe) < PPL)) m_cfg[cfg_lane][cfg_pe] = int'(cfg_count);
            end
            1, 2: begin
                if (abort) begin
                    m_phase = 0;
                    for (int g = 0; g < NL; g++) m_seq[g].delete();
                end else if (!any) begin
                    m_done_rd = (m_phase == 1);
                    m_phase = 3;
                end else if (beat) begin
                    for (int g = 0; g < NL; g++)
                        if (m_idx[g] < m_seq[g].size()) m_idx[g]++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock: compare outputs for current inputs, then advance the model
    task automatic step();
        bit any, e_pop, e_push;
        logic [31:0] e_rs, e_ws;
        #2;
        any = 1'b0;
        for (int g = 0; g < NL; g++) any |= lane_valid(g);
        e_pop  = (m_phase == 1) && !abort && any && !rd_buf_empty;
        e_push = (m_phase == 2) && !abort && any && !wr_buf_full;
`ifdef WEIGHT_XFER_STATS_EN
        e_rs = 32'(m_rd_stall);
        e_ws = 32'(m_wr_stall);
`else
        e_rs = 32'd0;
        e_ws = 32'd0;
`endif
        check("ctrl_pe", 32'(ctrl_pe), 32'(exp_ctrl()));
        check("rd_buf_pop", 32'(rd_buf_pop), 32'(e_pop));
        check("wr_buf_push", 32'(wr_buf_push), 32'(e_push));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("rd_done", 32'(rd_done), 32'((m_phase == 3) && m_done_rd));
        check("wr_done", 32'(wr_done), 32'((m_phase == 3) && !m_done_rd));
        check("rd_stall_cycles", rd_stall_cycles, e_rs);
        check("wr_stall_cycles", wr_stall_cycles, e_ws);
        o_pop = rd_buf_pop;
        o_push = wr_buf_push;
        o_rd_done = rd_done;
        o_wr_done = wr_done;
        o_ctrl = ctrl_pe;
        @(posedge ACLK);
        model_update(any, e_pop || e_push);
        @(negedge ACLK);
    endtask

    task automatic cfg_write(input int lane, input int pe, input int cnt);
        cfg_we = 1'b1;
        cfg_lane = LW'(lane);
        cfg_pe = PW'(pe);
        cfg_count = CW'(cnt);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic program_std();
        cfg_write(0, 0, 2); cfg_write(0, 1, 0); cfg_write(0, 2, 1);
        cfg_write(1, 0, 1); cfg_write(1, 1, 1); cfg_write(1, 2, 1);
    endtask

    // Start a phase and run to its done pulse; stalls on cycles sa/sb after start
    task automatic run_phase(input bit rd, input bit both, input int sa, input int sb,
                             input bit cfg_in_phase, input int exp_beats, input int exp_lat);
        int beats, lat;
        bit done;
        start_rd = rd || both;
        start_wr = !rd || both;
        step();
        start_rd = 1'b0;
        start_wr = 1'b0;
        beats = 0; lat = 0; done = 1'b0;
        q_beat_ctrl.delete();
        for (int c = 1; c <= 200 && !done; c++) begin
            rd_buf_empty = (c == sa) || (c == sb);
            wr_buf_full  = (c == sa) || (c == sb);
            if (cfg_in_phase && c == 1) begin
                cfg_we = 1'b1; cfg_lane = '0; cfg_pe = '0; cfg_count = 8'd7;
            end
            step();
            cfg_we = 1'b0;
            if (rd ? o_pop : o_push) begin
                beats++;
                q_beat_ctrl.push_back(o_ctrl);
            end
            if (rd ? o_rd_done : o_wr_done) begin
                done = 1'b1;
                lat = c;
            end
        end
        rd_buf_empty = 1'b0;
        wr_buf_full = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("beat_count", 32'(beats), 32'(exp_beats));
        check("done_latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        model_reset();
        @(negedge ACLK);
        step();
        step();
        ARESETN = 1'b1;
        step();

        // basic read-in: longest lane has 3 words
        program_std();
        run_phase(1'b1, 1'b0, -1, -1, 1'b0, 3, 5);
        check("beat_ctrl_n", 32'(q_beat_ctrl.size()), 32'd3);
        if (q_beat_ctrl.size() == 3) begin
            check("beat0_ctrl", 32'(q_beat_ctrl[0]), 32'h25);
            check("beat1_ctrl", 32'(q_beat_ctrl[1]), 32'h65);
            check("beat2_ctrl", 32'(q_beat_ctrl[2]), 32'hB5);
        end

        // empty buffer on the 2nd and 3rd cycles delays done by 2
        run_phase(1'b1, 1'b0, 2, 3, 1'b0, 3, 7);
`ifdef WEIGHT_XFER_STATS_EN
        check("rd_stall_total", rd_stall_cycles, 32'd2);
`else
        check("rd_stall_total", rd_stall_cycles, 32'd0);
`endif

        // same-cycle starts: RD wins; cfg writes during RD are dropped
        run_phase(1'b1, 1'b1, -1, -1, 1'b1, 3, 5);
        run_phase(1'b1, 1'b0, -1, -1, 1'b0, 3, 5);

        // abort after one beat, then a full re-run
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_no_done", 32'(o_rd_done), 32'd0);
        step();
        check("abort_idle", 32'(busy), 32'd0);
        run_phase(1'b1, 1'b0, -1, -1, 1'b0, 3, 5);

        // zero counts in write-back
        for (int g = 0; g < NL; g++)
            for (int p = 0; p < PPL; p++) cfg_write(g, p, 0);
        run_phase(1'b0, 1'b0, -1, -1, 1'b0, 0, 2);

        // asynchronous reset mid write-back
        program_std();
        start_wr = 1'b1;
        step();
        start_wr = 1'b0;
        step();
        #3 ARESETN = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_push", 32'(wr_buf_push), 32'd0);
        check("arst_ctrl", 32'(ctrl_pe), 32'd0);
        model_reset();
        step();
        step();
        ARESETN = 1'b1;
        run_phase(1'b1, 1'b0, -1, -1, 1'b0, 0, 2);

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 6)); w++)
                cfg_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
            start_rd = $urandom_range(0, 1) != 0;
            start_wr = !start_rd || ($urandom_range(0, 3) == 0);
            step();
            start_rd = 1'b0;
            start_wr = 1'b0;
            for (int c = 0; c < 150 && m_phase != 0; c++) begin
                rd_buf_empty = ($urandom_range(0, 3) == 0);
                wr_buf_full  = ($urandom_range(0, 3) == 0);
                abort        = ($urandom_range(0, 39) == 0);
                start_rd     = ($urandom_range(0, 7) == 0);
                start_wr     = ($urandom_range(0, 7) == 0);
                cfg_we       = ($urandom_range(0, 3) == 0);
                cfg_lane     = LW'($urandom_range(0, 1));
                cfg_pe       = PW'($urandom_range(0, 3));
                cfg_count    = CW'($urandom_range(0, 5));
                step();
            end
            rd_buf_empty = 1'b0; wr_buf_full = 1'b0; abort = 1'b0;
            start_rd = 1'b0; start_wr = 1'b0; cfg_we = 1'b0;
            check("rand_idle", 32'(busy), 32'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
